// File: rtl/dino_pkg.sv
// Shared types and default constants for the dino game core.
// Holds obstacle encodings and the spawner FSM state set.
package dino_pkg;

    typedef enum logic [1:0] {
        OBS_SMALL   = 2'd0,
        OBS_CLUSTER = 2'd1,
        OBS_LARGE   = 2'd2,
        OBS_BIRD    = 2'd3
    } obstacle_type_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAW  = 3'd1,
        LATCH = 3'd2,
        WAIT  = 3'd3,
        SPAWN = 3'd4
    } spawner_state_e;

    localparam int unsigned MIN_GAP_TICKS_DEF = 20;
    localparam int unsigned GAP_BITS_DEF      = 5;

endpackage

// File: rtl/spawn_gap_timer.sv
// Frame-tick down-counter that sets the spacing between obstacle spawns.
// The counter stops at zero; the owner decides what a tick at zero means.
module spawn_gap_timer #(
    parameter int GAP_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [GAP_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [GAP_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - GAP_W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/obstacle_spawner.sv
// Draws a random word from the LFSR, waits a random number of frame ticks,
// then offers one obstacle spawn over a valid/ready handshake.
module obstacle_spawner
    import dino_pkg::*;
#(
    parameter int unsigned MIN_GAP_TICKS = MIN_GAP_TICKS_DEF,
    parameter int unsigned GAP_BITS      = GAP_BITS_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        run_i,
    input  logic        tick_i,
    output logic        next_o,
    input  logic [15:0] rand_i,
    output logic        spawn_valid_o,
    input  logic        spawn_ready_i,
    output logic [1:0]  spawn_type_o,
    output logic [1:0]  spawn_var_o
);

    localparam int GAP_W = $clog2(MIN_GAP_TICKS + 2**GAP_BITS);

    spawner_state_e state_q, state_d;
    obstacle_type_e type_q;
    logic [1:0]     var_q;
    logic [GAP_W-1:0] gap_load;
    logic           gap_zero;

    // Bits between the gap field and the variant field carry no meaning here.
    logic unused_rand;
    assign unused_rand = ^rand_i[11:GAP_BITS];

    assign gap_load = GAP_W'(MIN_GAP_TICKS) + GAP_W'(rand_i[GAP_BITS-1:0]);

    spawn_gap_timer #(
        .GAP_W (GAP_W)
    ) u_gap_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (!run_i),
        .load_i     (state_q == LATCH),
        .load_val_i (gap_load),
        .dec_i      ((state_q == WAIT) && tick_i),
        .zero_o     (gap_zero)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Obstacle attributes clear whenever the game stops so IDLE shows all zeros.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !run_i) begin
            type_q <= OBS_SMALL;
            var_q  <= 2'b00;
        end else if (state_q == LATCH) begin
            type_q <= obstacle_type_e'(rand_i[15:14]);
            var_q  <= rand_i[13:12];
        end
    end

    always_comb begin
        state_d       = state_q;
        next_o        = 1'b0;
        spawn_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_i) state_d = DRAW;
            end
            DRAW: begin
                next_o  = 1'b1;
                state_d = LATCH;
            end
            LATCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (tick_i && gap_zero) state_d = SPAWN;
            end
            SPAWN: begin
                spawn_valid_o = 1'b1;
                if (spawn_ready_i) state_d = DRAW;
            end
            default: state_d = IDLE;
        endcase
        if (!run_i) state_d = IDLE;
    end

    assign spawn_type_o = type_q;
    assign spawn_var_o  = var_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner: scoreboarded spawns, handshake
// hold, dropped ticks, abort, mid-run reset and an LFSR-driven draw.
module tb_obstacle_spawner;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        run_i;
    logic        tick_i;
    logic        next_o;
    logic [15:0] rand_i;
    logic        spawn_valid_o;
    logic        spawn_ready_i;
    logic [1:0]  spawn_type_o;
    logic [1:0]  spawn_var_o;

    logic [15:0] rand_drv;
    logic [15:0] lfsr;
    bit          use_lfsr  = 1'b0;
    bit          lfsr_seed = 1'b0;
    bit          prev_next = 1'b0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] typ;
        logic [1:0] vr;
        int         ticks;
    } exp_t;

    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk_i) begin
        if (lfsr_seed) lfsr <= 16'h0001;
        else if (next_o) lfsr <= lfsr_step(lfsr);
    end

    assign rand_i = use_lfsr ? lfsr : rand_drv;

    obstacle_spawner dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .run_i         (run_i),
        .tick_i        (tick_i),
        .next_o        (next_o),
        .rand_i        (rand_i),
        .spawn_valid_o (spawn_valid_o),
        .spawn_ready_i (spawn_ready_i),
        .spawn_type_o  (spawn_type_o),
        .spawn_var_o   (spawn_var_o)
    );

    // next_o must never be high on two consecutive cycles.
    always @(posedge clk_i) begin
        #1;
        if (next_o === 1'b1) begin
            checks++;
            if (prev_next) begin
                failures++;
                $display("FAIL next_o_double: next_o high two cycles in a row at %0t", $time);
            end
        end
        prev_next = (next_o === 1'b1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Expected spawn derived from the random word: gap+1 ticks in WAIT.
    function automatic exp_t exp_from(input logic [15:0] r);
        exp_t e;
        e.typ   = r[15:14];
        e.vr    = r[13:12];
        e.ticks = 20 + int'(r[4:0]) + 1;
        return e;
    endfunction

    // Entered with next_o just observed high. Drives ticks and counts those
    // that land in WAIT (two cycles after DRAW) until spawn_valid_o rises.
    task automatic spawn_cycle(input bit tick_all, output int nticks, output bit got);
        int since_next;
        since_next = 0;
        nticks     = 0;
        got        = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            tick_i = tick_all || (c % 2 == 0);
            if (tick_i && since_next >= 2) nticks++;
            step();
            since_next++;
            if (spawn_valid_o === 1'b1) got = 1'b1;
        end
        tick_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; run_i = 1'b1; tick_i = 1'b0; spawn_ready_i = 1'b0;
        rand_drv = 16'h0000;
        step(); step();
        checks++; if (next_o !== 1'b0) begin failures++; $display("FAIL reset_next: got %b want 0", next_o); end
        checks++; if (spawn_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", spawn_valid_o); end
        checks++; if (spawn_type_o !== 2'd0) begin failures++; $display("FAIL reset_type: got %0d want 0", spawn_type_o); end
        checks++; if (spawn_var_o !== 2'd0) begin failures++; $display("FAIL reset_var: got %0d want 0", spawn_var_o); end
        run_i = 1'b0; rst_ni = 1'b1;
        step();
        checks++; if (next_o !== 1'b0) begin failures++; $display("FAIL idle_next: got %b want 0", next_o); end
    endtask

    task automatic test_basic();
        exp_t e; int nt; bit got;
        rand_drv = 16'h8005;
        sb.push_back(exp_from(rand_drv));
        run_i = 1'b1;
        step();
        checks++; if (next_o !== 1'b1) begin failures++; $display("FAIL basic_next_pulse: got %b want 1", next_o); end
        spawn_cycle(1'b0, nt, got);
        e = sb.pop_front();
        checks++; if (!got) begin failures++; $display("FAIL basic_timeout: valid never rose"); end
        checks++; if (nt !== e.ticks) begin failures++; $display("FAIL basic_ticks: got %0d want %0d", nt, e.ticks); end
        checks++; if (spawn_type_o !== e.typ) begin failures++; $display("FAIL basic_type: got %0d want %0d", spawn_type_o, e.typ); end
        checks++; if (spawn_var_o !== e.vr) begin failures++; $display("FAIL basic_var: got %0d want %0d", spawn_var_o, e.vr); end
    endtask

    task automatic test_hold();
        exp_t e; int nt; bit got;
        rand_drv = 16'hF01F;
        sb.push_back(exp_from(rand_drv));
        spawn_ready_i = 1'b1;
        step();
        spawn_ready_i = 1'b0;
        checks++; if (spawn_valid_o !== 1'b0) begin failures++; $display("FAIL hs1_valid: got %b want 0", spawn_valid_o); end
        checks++; if (next_o !== 1'b1) begin failures++; $display("FAIL hs1_next: got %b want 1", next_o); end
        spawn_cycle(1'b0, nt, got);
        e = sb.pop_front();
        checks++; if (!got) begin failures++; $display("FAIL hold_timeout: valid never rose"); end
        checks++; if (nt !== e.ticks) begin failures++; $display("FAIL hold_ticks: got %0d want %0d", nt, e.ticks); end
        for (int i = 0; i < 10; i++) begin
            tick_i = i[0];
            step();
            checks++; if (spawn_valid_o !== 1'b1) begin failures++; $display("FAIL hold_valid[%0d]: got %b want 1", i, spawn_valid_o); end
            checks++; if (spawn_type_o !== e.typ) begin failures++; $display("FAIL hold_type[%0d]: got %0d want %0d", i, spawn_type_o, e.typ); end
            checks++; if (spawn_var_o !== e.vr) begin failures++; $display("FAIL hold_var[%0d]: got %0d want %0d", i, spawn_var_o, e.vr); end
        end
        tick_i = 1'b0;
        rand_drv = 16'h0000;
        spawn_ready_i = 1'b1;
        step();
        spawn_ready_i = 1'b0;
        checks++; if (spawn_valid_o !== 1'b0) begin failures++; $display("FAIL hs2_valid: got %b want 0", spawn_valid_o); end
        checks++; if (next_o !== 1'b1) begin failures++; $display("FAIL hs2_next: got %b want 1", next_o); end
    endtask

    task automatic test_tick_drop();
        exp_t e; int nt; bit got;
        sb.push_back(exp_from(rand_drv));
        spawn_cycle(1'b1, nt, got);
        e = sb.pop_front();
        checks++; if (!got) begin failures++; $display("FAIL drop_timeout: valid never rose"); end
        checks++; if (nt !== e.ticks) begin failures++; $display("FAIL drop_ticks: got %0d want %0d", nt, e.ticks); end
        checks++; if (spawn_type_o !== e.typ) begin failures++; $display("FAIL drop_type: got %0d want %0d", spawn_type_o, e.typ); end
    endtask

    task automatic test_abort();
        run_i = 1'b0;
        step();
        checks++; if (spawn_valid_o !== 1'b0) begin failures++; $display("FAIL abort_valid: got %b want 0", spawn_valid_o); end
        checks++; if (next_o !== 1'b0) begin failures++; $display("FAIL abort_next: got %b want 0", next_o); end
        step();
        checks++; if (spawn_valid_o !== 1'b0) begin failures++; $display("FAIL abort_idle_valid: got %b want 0", spawn_valid_o); end
        run_i = 1'b1;
        step();
        checks++; if (next_o !== 1'b1) begin failures++; $display("FAIL abort_resume_next: got %b want 1", next_o); end
    endtask

    task automatic test_reset_mid();
        rand_drv = 16'hF01F;
        step(); step();
        tick_i = 1'b1;
        step(); step(); step();
        tick_i = 1'b0;
        rst_ni = 1'b0;
        step();
        checks++; if (next_o !== 1'b0) begin failures++; $display("FAIL rstmid_next: got %b want 0", next_o); end
        checks++; if (spawn_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b want 0", spawn_valid_o); end
        checks++; if (spawn_type_o !== 2'd0) begin failures++; $display("FAIL rstmid_type: got %0d want 0", spawn_type_o); end
        checks++; if (spawn_var_o !== 2'd0) begin failures++; $display("FAIL rstmid_var: got %0d want 0", spawn_var_o); end
        rst_ni = 1'b1;
        step();
        checks++; if (next_o !== 1'b1) begin failures++; $display("FAIL rstmid_release_next: got %b want 1", next_o); end
    endtask

    task automatic test_lfsr();
        exp_t e; int nt; bit got;
        rst_ni = 1'b0; run_i = 1'b0; lfsr_seed = 1'b1; use_lfsr = 1'b1;
        step();
        lfsr_seed = 1'b0; rst_ni = 1'b1; run_i = 1'b1;
        e.typ = 2'd0; e.vr = 2'd0; e.ticks = 23;
        sb.push_back(e);
        step();
        checks++; if (next_o !== 1'b1) begin failures++; $display("FAIL lfsr_next: got %b want 1", next_o); end
        spawn_cycle(1'b0, nt, got);
        e = sb.pop_front();
        checks++; if (!got) begin failures++; $display("FAIL lfsr_timeout: valid never rose"); end
        checks++; if (nt !== e.ticks) begin failures++; $display("FAIL lfsr_ticks: got %0d want %0d", nt, e.ticks); end
        checks++; if (spawn_type_o !== e.typ) begin failures++; $display("FAIL lfsr_type: got %0d want %0d", spawn_type_o, e.typ); end
        checks++; if (spawn_var_o !== e.vr) begin failures++; $display("FAIL lfsr_var: got %0d want %0d", spawn_var_o, e.vr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_tick_drop();
        test_abort();
        test_reset_mid();
        test_lfsr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
